// File: rtl/lfsr_rand_gen.sv
// XNOR Fibonacci LFSR pseudo-random generator.
// Built-in maximal-length tap table for widths 3..32. Advances BITS_PER_CYCLE
// steps per enabled clock. Never loads the all-ones lock-up seed. Gives a
// registered pulse each time the sequence passes its start value.
// Optional build macro LFSR_RANGE_EN adds a two-stage bounded-range sampler
// that maps the current state into 0..i_Range_Max.
module lfsr_rand_gen #(
  parameter int NUM_BITS       = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
`ifdef LFSR_RANGE_EN
  input  logic                i_Range_Req,
  input  logic [NUM_BITS-1:0] i_Range_Max,
  output logic [NUM_BITS-1:0] o_Range_Data,
  output logic                o_Range_DV,
  output logic                o_Range_Busy,
`endif
  output logic [NUM_BITS-1:0] o_LFSR_Data,
  output logic                o_LFSR_Done,
  output logic                o_Seed_Err
);

  if (NUM_BITS < 3 || NUM_BITS > 32) begin : g_bad_width
    $error("lfsr_rand_gen: NUM_BITS must be 3..32");
  end
  if (BITS_PER_CYCLE < 1 || BITS_PER_CYCLE > NUM_BITS) begin : g_bad_step
    $error("lfsr_rand_gen: BITS_PER_CYCLE must be 1..NUM_BITS");
  end

  // Tap mask: bit k-1 is set for tap k. Values come from the XAPP052
  // maximal-length table.
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    case (n)
      3:  m = (32'h1 << 2)  | (32'h1 << 1);
      4:  m = (32'h1 << 3)  | (32'h1 << 2);
      5:  m = (32'h1 << 4)  | (32'h1 << 2);
      6:  m = (32'h1 << 5)  | (32'h1 << 4);
      7:  m = (32'h1 << 6)  | (32'h1 << 5);
      8:  m = (32'h1 << 7)  | (32'h1 << 5)  | (32'h1 << 4) | (32'h1 << 3);
      9:  m = (32'h1 << 8)  | (32'h1 << 4);
      10: m = (32'h1 << 9)  | (32'h1 << 6);
      11: m = (32'h1 << 10) | (32'h1 << 8);
      12: m = (32'h1 << 11) | (32'h1 << 5)  | (32'h1 << 3) | (32'h1 << 0);
      13: m = (32'h1 << 12) | (32'h1 << 3)  | (32'h1 << 2) | (32'h1 << 0);
      14: m = (32'h1 << 13) | (32'h1 << 4)  | (32'h1 << 2) | (32'h1 << 0);
      15: m = (32'h1 << 14) | (32'h1 << 13);
      16: m = (32'h1 << 15) | (32'h1 << 14) | (32'h1 << 12) | (32'h1 << 3);
      17: m = (32'h1 << 16) | (32'h1 << 13);
      18: m = (32'h1 << 17) | (32'h1 << 10);
      19: m = (32'h1 << 18) | (32'h1 << 5)  | (32'h1 << 1) | (32'h1 << 0);
      20: m = (32'h1 << 19) | (32'h1 << 16);
      21: m = (32'h1 << 20) | (32'h1 << 18);
      22: m = (32'h1 << 21) | (32'h1 << 20);
      23: m = (32'h1 << 22) | (32'h1 << 17);
      24: m = (32'h1 << 23) | (32'h1 << 22) | (32'h1 << 21) | (32'h1 << 16);
      25: m = (32'h1 << 24) | (32'h1 << 21);
      26: m = (32'h1 << 25) | (32'h1 << 5)  | (32'h1 << 1) | (32'h1 << 0);
      27: m = (32'h1 << 26) | (32'h1 << 4)  | (32'h1 << 1) | (32'h1 << 0);
      28: m = (32'h1 << 27) | (32'h1 << 24);
      29: m = (32'h1 << 28) | (32'h1 << 26);
      30: m = (32'h1 << 29) | (32'h1 << 5)  | (32'h1 << 3) | (32'h1 << 0);
      31: m = (32'h1 << 30) | (32'h1 << 27);
      32: m = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | (32'h1 << 0);
      default: m = (32'h1 << 2) | (32'h1 << 1);
    endcase
    return m;
  endfunction

  localparam logic [31:0]         TAP32 = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAPS  = TAP32[NUM_BITS-1:0];

  // Single XNOR step. Feedback goes in at the LSB, so all-zeros moves on
  // and all-ones maps back to itself.
  function automatic logic [NUM_BITS-1:0] step(input logic [NUM_BITS-1:0] s);
    return {s[NUM_BITS-2:0], ~^(s & TAPS)};
  endfunction

  logic [NUM_BITS-1:0] lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0] start_q, start_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Unrolled multi-step advance. Flags a pass through the start value at any
  // of the intermediate states.
  always_comb begin
    logic [NUM_BITS-1:0] st;
    logic                hit;
    st      = lfsr_q;
    hit     = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      st = step(st);
      if (st == start_q) hit = 1'b1;
    end
    lfsr_d  = lfsr_q;
    start_d = start_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (i_Seed_DV) begin
      if (&i_Seed_Data) begin
        lfsr_d  = '0;
        start_d = '0;
        err_d   = 1'b1;
      end else begin
        lfsr_d  = i_Seed_Data;
        start_d = i_Seed_Data;
      end
    end else if (i_Enable) begin
      lfsr_d = st;
      done_d = hit;
    end
  end

  // Core state registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      lfsr_q  <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_LFSR_Data = lfsr_q;
  assign o_LFSR_Done = done_q;
  assign o_Seed_Err  = err_q;

`ifdef LFSR_RANGE_EN
  logic [NUM_BITS-1:0] snap_q, max_q, rdata_q;
  logic [2*NUM_BITS:0] prod_q;
  logic                busy_q, s1_q, s2_q, rdv_q;
  logic [2*NUM_BITS:0] prod_w;

  // Scale the snapshot by (max+1). The top NUM_BITS bits of that product
  // give a value in 0..max.
  assign prod_w = {{(NUM_BITS+1){1'b0}}, snap_q} *
                  {{NUM_BITS{1'b0}}, ({1'b0, max_q} + 1'b1)};

  // Sampler pipeline: accept, multiply, then shift out. Only one sample is
  // in flight at a time.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      snap_q  <= '0;
      max_q   <= '0;
      prod_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      rdv_q <= 1'b0;
      s1_q  <= 1'b0;
      s2_q  <= s1_q;
      if (i_Range_Req && !busy_q) begin
        snap_q <= lfsr_q;
        max_q  <= i_Range_Max;
        busy_q <= 1'b1;
        s1_q   <= 1'b1;
      end
      if (s1_q) prod_q <= prod_w;
      if (s2_q) begin
        rdata_q <= NUM_BITS'(prod_q >> NUM_BITS);
        rdv_q   <= 1'b1;
        busy_q  <= 1'b0;
      end
    end
  end

  assign o_Range_Data = rdata_q;
  assign o_Range_DV   = rdv_q;
  assign o_Range_Busy = busy_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen. Two N=3 instances, one with 1 step per
// clock and one with 2, share the same stimulus. The range sampler is
// exercised when LFSR_RANGE_EN is defined.
module tb_lfsr_rand_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, sdv;
  logic [2:0] sdata;
  logic [2:0] d1, d2;
  logic       dn1, dn2, er1, er2;
`ifdef LFSR_RANGE_EN
  logic       req, req2;
  logic [2:0] rmax, rd1, rd2;
  logic       rdv1, rdv2, rbz1, rbz2;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  lfsr_rand_gen #(.NUM_BITS(3), .BITS_PER_CYCLE(1)) u1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Seed_DV(sdv),
    .i_Seed_Data(sdata),
`ifdef LFSR_RANGE_EN
    .i_Range_Req(req), .i_Range_Max(rmax), .o_Range_Data(rd1),
    .o_Range_DV(rdv1), .o_Range_Busy(rbz1),
`endif
    .o_LFSR_Data(d1), .o_LFSR_Done(dn1), .o_Seed_Err(er1));

  lfsr_rand_gen #(.NUM_BITS(3), .BITS_PER_CYCLE(2)) u2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Seed_DV(sdv),
    .i_Seed_Data(sdata),
`ifdef LFSR_RANGE_EN
    .i_Range_Req(req2), .i_Range_Max(rmax), .o_Range_Data(rd2),
    .o_Range_DV(rdv2), .o_Range_Busy(rbz2),
`endif
    .o_LFSR_Data(d2), .o_LFSR_Done(dn2), .o_Seed_Err(er2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent one-step reference for the 3-bit XNOR taps {3,2}.
  function automatic logic [2:0] ref_step(input logic [2:0] s);
    return {s[1:0], ~(s[2] ^ s[1])};
  endfunction

  logic [2:0] seq1 [7];
  logic [2:0] seq2 [7];
  logic [2:0] sd1  [7];
  logic [2:0] sd2  [7];
  logic [2:0] m, ma;
  logic       mh;

  initial begin
    seq1 = '{3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd0};
    seq2 = '{3'd3, 3'd5, 3'd4, 3'd1, 3'd6, 3'd2, 3'd0};
    sd1  = '{3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd6, 3'd5};
    sd2  = '{3'd4, 3'd1, 3'd6, 3'd2, 3'd0, 3'd3, 3'd5};
    rst_n = 1'b0; en = 1'b0; sdv = 1'b0; sdata = '0;
`ifdef LFSR_RANGE_EN
    req = 1'b0; req2 = 1'b0; rmax = '0;
`endif
    #2;
    chk("rst_data", 32'(d1), 0);
    chk("rst_done", 32'(dn1), 0);
    chk("rst_err",  32'(er1), 0);
`ifdef LFSR_RANGE_EN
    chk("rst_rdv",  32'(rdv1), 0);
    chk("rst_rbusy", 32'(rbz1), 0);
`endif

    // Free run from zero, two full periods
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    m = 3'd0;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk($sformatf("b1_data%0d", i), 32'(d1), 32'(seq1[i % 7]));
      chk($sformatf("b1_done%0d", i), 32'(dn1), 32'((i % 7) == 6));
      chk($sformatf("b2_data%0d", i), 32'(d2), 32'(seq2[i % 7]));
      chk($sformatf("b2_done%0d", i), 32'(dn2), 32'((i % 7) == 3 || (i % 7) == 6));
      ma = ref_step(m); mh = (ma == 3'd0);
      m  = ref_step(ma); mh = mh | (m == 3'd0);
      chk($sformatf("b2_model_data%0d", i), 32'(d2), 32'(m));
      chk($sformatf("b2_model_done%0d", i), 32'(dn2), 32'(mh));
    end

    // Lock-up seed replaced by zero
    en = 1'b0; sdv = 1'b1; sdata = 3'b111;
    tick();
    chk("bad_seed_data", 32'(d1), 0);
    chk("bad_seed_err",  32'(er1), 1);
    chk("bad_seed_err2", 32'(er2), 1);
    chk("bad_seed_done", 32'(dn1), 0);
    sdv = 1'b0;
    tick();
    chk("bad_seed_err_pulse", 32'(er1), 0);

    // Legal seed, then one period back to it
    sdv = 1'b1; sdata = 3'b101;
    tick();
    chk("seed5_data", 32'(d1), 5);
    chk("seed5_err",  32'(er1), 0);
    sdv = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("s5_b1_data%0d", i), 32'(d1), 32'(sd1[i]));
      chk($sformatf("s5_b1_done%0d", i), 32'(dn1), 32'(i == 6));
      chk($sformatf("s5_b2_data%0d", i), 32'(d2), 32'(sd2[i]));
      chk($sformatf("s5_b2_done%0d", i), 32'(dn2), 32'(i == 3 || i == 6));
    end

    // Seed wins over enable; hold with enable low
    sdv = 1'b1; sdata = 3'd3; en = 1'b1;
    tick();
    chk("prio_data1", 32'(d1), 3);
    chk("prio_data2", 32'(d2), 3);
    chk("prio_done",  32'(dn1), 0);
    sdv = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold_data%0d", i), 32'(d1), 3);
      chk($sformatf("hold_done%0d", i), 32'(dn1), 0);
    end

    // Asynchronous reset between edges clears state and pulses at once
    sdv = 1'b1; sdata = 3'b111;
    tick();
    chk("pre_rst_err", 32'(er1), 1);
    sdv = 1'b0; sdata = 3'd6;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_err",  32'(er1), 0);
    chk("async_rst_data", 32'(d2), 0);
    chk("async_rst_done", 32'(dn1), 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    tick();
    chk("post_rst_data", 32'(d1), 1);
    en = 1'b0;

`ifdef LFSR_RANGE_EN
    sdv = 1'b1; sdata = 3'd5;
    tick();
    sdv = 1'b0; req = 1'b1; rmax = 3'd5;
    tick();
    chk("rng_busy0", 32'(rbz1), 1);
    chk("rng_dv0",   32'(rdv1), 0);
    rmax = 3'd0;           // request during busy must be ignored
    tick();
    chk("rng_busy1", 32'(rbz1), 1);
    chk("rng_dv1",   32'(rdv1), 0);
    req = 1'b0;
    tick();
    chk("rng_dv2",   32'(rdv1), 1);
    chk("rng_data",  32'(rd1), 3);
    chk("rng_busy2", 32'(rbz1), 0);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    chk("rng_max0_dv",   32'(rdv1), 1);
    chk("rng_max0_data", 32'(rd1), 0);
    tick();
    chk("rng_dv_pulse", 32'(rdv1), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
